mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the ARM-subset datapath (PC, instruction register, register file, ALU, extender, data memory). It decodes the latched instruction, evaluates the condition field against a stored NZCV register, and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. It drives every datapath select and write-enable, and runs a req/ack handshake with a variable-latency data memory. It replaces the fixed single-cycle decoder, so one datapath serves a memory that can stall.

---
 rtl/mc_ctrl_if.sv | 33 +++
 rtl/mc_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the ARM-subset datapath.
// master = sequencer side, slave = datapath/memory side.
interface mc_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  alu_flags;
  logic        dmem_ack;
  logic        IR_en;
  logic        PC_en;
  logic        PC_src;
  logic        RF_en;
  logic        D_en;
  logic        MemtoReg;
  logic        ALUSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUcntrl;
  logic        dmem_req;
  logic        instr_done;
  logic        illegal;
  logic        bus_err;

  modport master (
    input  Instr, alu_flags, dmem_ack,
    output IR_en, PC_en, PC_src, RF_en, D_en, MemtoReg, ALUSrc,
           RegSrc, ImmSrc, ALUcntrl, dmem_req, instr_done, illegal, bus_err
  );

  modport slave (
    output Instr, alu_flags, dmem_ack,
    input  IR_en, PC_en, PC_src, RF_en, D_en, MemtoReg, ALUSrc,
           RegSrc, ImmSrc, ALUcntrl, dmem_req, instr_done, illegal, bus_err
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with NZCV condition checks
// and a timed req/ack handshake towards a variable-latency data memory.
module mc_ctrl #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ABORT
  } state_e;

  typedef struct packed {
    logic       ill;
    logic       cond_ok;
    logic [1:0] cls;
    logic       cmp;
    logic       setf;
    logic       load;
    logic       rd15;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic [1:0] aluctl;
  } dec_t;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;

  state_e            state_q, state_d;
  logic [3:0]        flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dec_t              dec_q, dec_d;

  logic ir_en, pc_en, pc_src, rf_en, d_en, m2r, req, ill_pulse, berr;

  // Flags are packed {N,Z,C,V}; code 1111 never passes and is trapped as illegal.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_comb begin
    dec_d         = '0;
    dec_d.cls     = bus.Instr[27:26];
    dec_d.rd15    = (bus.Instr[15:12] == 4'hF);
    dec_d.cond_ok = cond_pass(bus.Instr[31:28], flags_q);
    case (bus.Instr[27:26])
      CLS_DP: begin
        dec_d.alusrc = bus.Instr[25];
        dec_d.setf   = bus.Instr[20];
        case (bus.Instr[24:21])
          4'b0100: dec_d.aluctl = 2'b00;
          4'b0010: dec_d.aluctl = 2'b01;
          4'b0000: dec_d.aluctl = 2'b10;
          4'b1100: dec_d.aluctl = 2'b11;
          4'b1010: begin
            dec_d.aluctl = 2'b01;
            dec_d.cmp    = 1'b1;
            dec_d.setf   = 1'b1;
          end
          default: dec_d.ill = 1'b1;
        endcase
      end
      CLS_MEM: begin
        dec_d.alusrc    = 1'b1;
        dec_d.immsrc    = 2'b01;
        dec_d.load      = bus.Instr[20];
        dec_d.regsrc[0] = !bus.Instr[20];
      end
      CLS_BR: begin
        dec_d.alusrc = 1'b1;
        dec_d.immsrc = 2'b10;
        dec_d.regsrc = 2'b10;
      end
      default: dec_d.ill = 1'b1;
    endcase
    if (bus.Instr[31:28] == 4'hF) dec_d.ill = 1'b1;
    // An undecodable word drives no datapath selects at all.
    if (dec_d.ill) begin
      dec_d.regsrc = '0;
      dec_d.immsrc = '0;
      dec_d.alusrc = 1'b0;
      dec_d.aluctl = '0;
      dec_d.cmp    = 1'b0;
      dec_d.setf   = 1'b0;
      dec_d.load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= '0;
      cnt_q   <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) dec_q <= dec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    rf_en     = 1'b0;
    d_en      = 1'b0;
    m2r       = 1'b0;
    req       = 1'b0;
    ill_pulse = 1'b0;
    berr      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_q.ill || !dec_q.cond_ok) begin
          pc_en     = 1'b1;
          ill_pulse = dec_q.ill;
          state_d   = S_FETCH;
        end else begin
          case (dec_q.cls)
            CLS_DP: begin
              rf_en   = !dec_q.cmp;
              pc_en   = 1'b1;
              pc_src  = dec_q.rd15;
              if (dec_q.setf) flags_d = bus.alu_flags;
              state_d = S_FETCH;
            end
            CLS_MEM: begin
              cnt_d   = '0;
              state_d = S_MEM;
            end
            default: begin
              pc_en   = 1'b1;
              pc_src  = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_MEM: begin
        req  = 1'b1;
        d_en = !dec_q.load;
        // Ack on the threshold cycle still completes the access.
        if (bus.dmem_ack) begin
          if (dec_q.load) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        rf_en   = 1'b1;
        m2r     = 1'b1;
        pc_en   = 1'b1;
        pc_src  = dec_q.rd15;
        state_d = S_FETCH;
      end
      S_ABORT: begin
        berr    = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low immediately, including the cycle it is first seen.
  assign bus.IR_en      = ir_en & ~reset;
  assign bus.PC_en      = pc_en & ~reset;
  assign bus.PC_src     = pc_src & ~reset;
  assign bus.RF_en      = rf_en & ~reset;
  assign bus.D_en       = d_en & ~reset;
  assign bus.MemtoReg   = m2r & ~reset;
  assign bus.dmem_req   = req & ~reset;
  assign bus.instr_done = pc_en & ~reset;
  assign bus.illegal    = ill_pulse & ~reset;
  assign bus.bus_err    = berr & ~reset;
  assign bus.RegSrc     = reset ? 2'b00 : dec_q.regsrc;
  assign bus.ImmSrc     = reset ? 2'b00 : dec_q.immsrc;
  assign bus.ALUSrc     = dec_q.alusrc & ~reset;
  assign bus.ALUcntrl   = reset ? 2'b00 : dec_q.aluctl;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle control vectors for each instruction class,
// memory waits, timeout abort, illegal words and reset during a memory access.
module tb_mc_ctrl;

  localparam logic [9:0] C_IR    = 10'h200;
  localparam logic [9:0] C_PCEN  = 10'h100;
  localparam logic [9:0] C_PCSRC = 10'h080;
  localparam logic [9:0] C_RF    = 10'h040;
  localparam logic [9:0] C_DEN   = 10'h020;
  localparam logic [9:0] C_M2R   = 10'h010;
  localparam logic [9:0] C_REQ   = 10'h008;
  localparam logic [9:0] C_DONE  = 10'h004;
  localparam logic [9:0] C_ILL   = 10'h002;
  localparam logic [9:0] C_BERR  = 10'h001;

  // {RegSrc, ImmSrc, ALUSrc, ALUcntrl}
  localparam logic [6:0] SEL_ADDI = 7'b00_00_1_00;
  localparam logic [6:0] SEL_CMP  = 7'b00_00_1_01;
  localparam logic [6:0] SEL_BR   = 7'b10_10_1_00;
  localparam logic [6:0] SEL_LDR  = 7'b00_01_1_00;
  localparam logic [6:0] SEL_STR  = 7'b01_01_1_00;
  localparam logic [6:0] SEL_NONE = 7'b00_00_0_00;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [6:0] last_sel;

  mc_ctrl_if bus ();

  mc_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] ctl;
  logic [6:0] sel;
  assign ctl = {bus.IR_en, bus.PC_en, bus.PC_src, bus.RF_en, bus.D_en, bus.MemtoReg,
                bus.dmem_req, bus.instr_done, bus.illegal, bus.bus_err};
  assign sel = {bus.RegSrc, bus.ImmSrc, bus.ALUSrc, bus.ALUcntrl};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic ack, input logic [3:0] fl,
                      input logic [9:0] ec, input logic [6:0] es);
    bus.dmem_ack  = ack;
    bus.alu_flags = fl;
    #1;
    chk({tag, "/ctl"}, 32'(ctl), 32'(ec));
    chk({tag, "/sel"}, 32'(sel), 32'(es));
    @(negedge clk);
  endtask

  task automatic instr3(input string tag, input logic [31:0] ins, input logic ack,
                        input logic [3:0] fl, input logic [9:0] ec, input logic [6:0] es);
    bus.Instr = ins;
    step({tag, "/F"}, ack, 4'h0, C_IR, last_sel);
    step({tag, "/D"}, ack, 4'h0, 10'h000, last_sel);
    step({tag, "/E"}, ack, fl, ec, es);
    last_sel = es;
  endtask

  task automatic mem_front(input string tag, input logic [31:0] ins, input logic [6:0] es);
    bus.Instr = ins;
    step({tag, "/F"}, 1'b0, 4'h0, C_IR, last_sel);
    step({tag, "/D"}, 1'b0, 4'h0, 10'h000, last_sel);
    step({tag, "/E"}, 1'b0, 4'h0, 10'h000, es);
    last_sel = es;
  endtask

  initial begin
    reset         = 1'b1;
    bus.Instr     = 32'h0;
    bus.dmem_ack  = 1'b0;
    bus.alu_flags = 4'h0;
    last_sel      = SEL_NONE;

    step("rst0", 1'b1, 4'hF, 10'h000, SEL_NONE);
    step("rst1", 1'b1, 4'hF, 10'h000, SEL_NONE);
    reset = 1'b0;

    instr3("add",     32'hE2821005, 1'b0, 4'h0, C_RF | C_PCEN | C_DONE, SEL_ADDI);
    instr3("add_pc",  32'hE282F005, 1'b0, 4'h0, C_RF | C_PCEN | C_PCSRC | C_DONE, SEL_ADDI);
    instr3("cmp",     32'hE3510000, 1'b0, 4'b0100, C_PCEN | C_DONE, SEL_CMP);
    instr3("add_nos", 32'hE2821005, 1'b0, 4'b0000, C_RF | C_PCEN | C_DONE, SEL_ADDI);
    instr3("bne_f",   32'h1AFFFFFE, 1'b0, 4'h0, C_PCEN | C_DONE, SEL_BR);
    instr3("beq_t",   32'h0AFFFFFE, 1'b1, 4'h0, C_PCEN | C_PCSRC | C_DONE, SEL_BR);
    instr3("adds",    32'hE2921005, 1'b0, 4'b0000, C_RF | C_PCEN | C_DONE, SEL_ADDI);
    instr3("bne_t",   32'h1AFFFFFE, 1'b0, 4'h0, C_PCEN | C_PCSRC | C_DONE, SEL_BR);

    mem_front("ldr", 32'hE5943008, SEL_LDR);
    step("ldr/M0", 1'b0, 4'h0, C_REQ, SEL_LDR);
    step("ldr/M1", 1'b0, 4'h0, C_REQ, SEL_LDR);
    step("ldr/M2", 1'b1, 4'h0, C_REQ, SEL_LDR);
    step("ldr/WB", 1'b0, 4'h0, C_RF | C_M2R | C_PCEN | C_DONE, SEL_LDR);

    mem_front("str", 32'hE5843008, SEL_STR);
    step("str/M0", 1'b1, 4'h0, C_DEN | C_REQ | C_PCEN | C_DONE, SEL_STR);

    mem_front("ldrpc", 32'hE594F008, SEL_LDR);
    step("ldrpc/M0", 1'b1, 4'h0, C_REQ, SEL_LDR);
    step("ldrpc/WB", 1'b0, 4'h0, C_RF | C_M2R | C_PCEN | C_PCSRC | C_DONE, SEL_LDR);

    mem_front("to", 32'hE5943008, SEL_LDR);
    for (int i = 0; i < 4; i++) step($sformatf("to/M%0d", i), 1'b0, 4'h0, C_REQ, SEL_LDR);
    step("to/ABT", 1'b0, 4'h0, C_BERR | C_PCEN | C_DONE, SEL_LDR);

    instr3("ill",      32'hEC000000, 1'b0, 4'h0, C_ILL | C_PCEN | C_DONE, SEL_NONE);
    instr3("ill_cond", 32'hF2821005, 1'b0, 4'h0, C_ILL | C_PCEN | C_DONE, SEL_NONE);
    instr3("ill_cmd",  32'hE2A21005, 1'b0, 4'h0, C_ILL | C_PCEN | C_DONE, SEL_NONE);

    instr3("cmp2", 32'hE3510000, 1'b0, 4'b0100, C_PCEN | C_DONE, SEL_CMP);
    mem_front("rstm", 32'hE5943008, SEL_LDR);
    step("rstm/M0", 1'b0, 4'h0, C_REQ, SEL_LDR);
    reset = 1'b1;
    step("rstm/R", 1'b1, 4'h0, 10'h000, SEL_NONE);
    reset    = 1'b0;
    last_sel = SEL_NONE;
    instr3("beq_rst", 32'h0AFFFFFE, 1'b0, 4'h0, C_PCEN | C_DONE, SEL_BR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
